// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and defaults for the fetch/LSU memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int LS_MAX_STREAK_DEF = 4;

    localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - owner selection with a starvation-bounding LSU streak counter
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int LS_MAX_STREAK = LS_MAX_STREAK_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   if_req,
    input  logic   ls_req,
    input  logic   arb_en,
    output logic   pick_valid,
    output owner_t pick_owner
);

    localparam int SW = $clog2(LS_MAX_STREAK + 2);

    logic [SW-1:0] streak;
    logic          streak_full;

    assign streak_full = (streak == SW'(LS_MAX_STREAK));
    assign pick_valid  = if_req | ls_req;

    // LSU has priority unless it has already starved a waiting fetch for the full streak
    always_comb begin
        pick_owner = OWN_IF;
        if (ls_req && !(if_req && streak_full)) begin
            pick_owner = OWN_LS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (arb_en && pick_valid) begin
            if (pick_owner == OWN_LS && if_req) begin
                if (!streak_full) begin
                    streak <= streak + SW'(1);
                end
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter between instruction fetch and LSU onto one memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LS_MAX_STREAK = LS_MAX_STREAK_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    owner_t      owner_q;
    owner_t      pick_owner;
    logic        pick_valid;
    logic        arb_en;
    logic [31:0] rdata_q;

    assign arb_en = (state == ST_IDLE);

    mem_arb_pick #(
        .LS_MAX_STREAK (LS_MAX_STREAK)
    ) u_pick (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .ls_req     (ls_req),
        .arb_en     (arb_en),
        .pick_valid (pick_valid),
        .pick_owner (pick_owner)
    );

    // Grants are combinational so a request is acknowledged in the cycle it is seen
    assign if_gnt = arb_en && pick_valid && (pick_owner == OWN_IF);
    assign ls_gnt = arb_en && pick_valid && (pick_owner == OWN_LS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner_q   <= OWN_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            rdata_q   <= '0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_owner;
                        mem_req <= 1'b1;
                        if (pick_owner == OWN_LS) begin
                            mem_we    <= ls_we;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            mem_be    <= ls_be;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_be    <= BE_FULL;
                        end
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_rvalid) begin
                            rdata_q <= mem_rdata;
                            state   <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Response is registered here, so the owner sees rvalid the cycle after RESP
                    if (owner_q == OWN_LS) begin
                        ls_rvalid <= 1'b1;
                        ls_rdata  <= rdata_q;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= rdata_q;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int passed = 0;
    int total  = 0;

    logic [31:0] last_if;
    logic [31:0] last_ls;

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gnt_wait;
        int          rv_wait;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[5];

    mem_arbiter #(.LS_MAX_STREAK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_be      (ls_be),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %b, expected %b", name, act, exp);
        else passed++;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_no_rvalid(input string name);
        chk1({name, "_if_rvalid"}, if_rvalid, 1'b0);
        chk1({name, "_ls_rvalid"}, ls_rvalid, 1'b0);
    endtask

    // Called at a negedge with the arbiter idle; returns at a negedge, idle again
    task automatic do_txn(input vec_t v);
        if (v.is_ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata; ls_be = v.be;
            if_addr = ~v.addr;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
            ls_we = v.we; ls_addr = ~v.addr; ls_wdata = v.wdata; ls_be = v.be;
        end
        #1;
        chk1("if_gnt", if_gnt, !v.is_ls);
        chk1("ls_gnt", ls_gnt, v.is_ls);
        chk1("mem_req_idle", mem_req, 1'b0);
        tick;
        if_req = 1'b0; ls_req = 1'b0;
        ls_addr = 32'hBAD0_0000; if_addr = 32'hBAD1_0000; ls_wdata = 32'hFFFF_FFFF; ls_be = 4'h0; ls_we = ~v.we;
        for (int c = 0; c <= v.gnt_wait; c++) begin
            if (c == v.gnt_wait) begin
                mem_gnt = 1'b1; mem_rvalid = (v.rv_wait == 0); mem_rdata = v.rdata;
            end
            #1;
            chk1("mem_req", mem_req, 1'b1);
            chk1("mem_we", mem_we, v.exp_we);
            chk32("mem_addr", mem_addr, v.addr);
            chk32("mem_wdata", mem_wdata, v.exp_wdata);
            chk32("mem_be", {28'd0, mem_be}, {28'd0, v.exp_be});
            chk1("gnt_clear", if_gnt | ls_gnt, 1'b0);
            tick;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
        end
        for (int c = 1; c <= v.rv_wait; c++) begin
            if (c == v.rv_wait) begin
                mem_rvalid = 1'b1; mem_rdata = v.rdata;
            end
            #1;
            chk1("mem_req_wait", mem_req, 1'b0);
            chk_no_rvalid("wait");
            tick;
            mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
        end
        #1;
        chk_no_rvalid("resp");
        tick;
        if (v.is_ls) last_ls = v.rdata;
        else last_if = v.rdata;
        chk1("ls_rvalid", ls_rvalid, v.is_ls);
        chk1("if_rvalid", if_rvalid, !v.is_ls);
        chk32("ls_rdata", ls_rdata, last_ls);
        chk32("if_rdata", if_rdata, last_if);
        tick;
        chk_no_rvalid("after");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_ls;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 2, 3, 32'hDEAD_BEEF, 1'b0, 32'h0,         4'hF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0204, 32'h0000_00AB, 4'h1, 0, 1, 32'h0,         1'b1, 32'h0000_00AB, 4'h1};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 0, 0, 32'h1357_9BDF, 1'b0, 32'h0,         4'hF};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_1004, 32'h1234_5678, 4'h3, 1, 2, 32'hCAFE_F00D, 1'b0, 32'h0,         4'hF};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         4'hC, 1, 0, 32'hA5A5_A5A5, 1'b0, 32'h0,         4'hC};

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_wdata = '0; ls_be = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        last_if = '0; last_ls = '0;
        @(negedge clk);
        @(negedge clk);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_be", {28'd0, mem_be}, 32'h0);
        chk_no_rvalid("rst");
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_ls_rdata", ls_rdata, 32'h0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 5; i++) do_txn(vecs[i]);

        // Stray response while idle must not reach either port
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_no_rvalid("stray_idle");
            chk1("stray_mem_req", mem_req, 1'b0);
        end
        mem_rvalid = 1'b0;
        tick;
        chk32("stray_if_rdata", if_rdata, last_if);
        chk32("stray_ls_rdata", ls_rdata, last_ls);

        // Contention with memory answering in the grant cycle: LSU streak capped at 4
        if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h0000_2000; ls_addr = 32'h0000_3000;
        ls_we = 1'b0; ls_be = 4'hF; ls_wdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            exp_ls = (i % 5 != 4);
            #1;
            chk1("cont_ls_gnt", ls_gnt, exp_ls);
            chk1("cont_if_gnt", if_gnt, !exp_ls);
            tick;
            mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0A00 + 32'(i);
            #1;
            chk32("cont_mem_addr", mem_addr, exp_ls ? 32'h0000_3000 : 32'h0000_2000);
            tick;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            #1;
            chk_no_rvalid("cont_resp");
            tick;
            if (exp_ls) last_ls = 32'h0000_0A00 + 32'(i);
            else last_if = 32'h0000_0A00 + 32'(i);
            chk1("cont_ls_rvalid", ls_rvalid, exp_ls);
            chk1("cont_if_rvalid", if_rvalid, !exp_ls);
            chk32("cont_ls_rdata", ls_rdata, last_ls);
            chk32("cont_if_rdata", if_rdata, last_if);
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick;

        // Reset while waiting for the response abandons the transaction
        ls_req = 1'b1; ls_addr = 32'h0000_0500; ls_we = 1'b1; ls_wdata = 32'h0000_00EE; ls_be = 4'h2;
        #1;
        chk1("rw_ls_gnt", ls_gnt, 1'b1);
        tick;
        ls_req = 1'b0; mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        #1;
        chk1("rw_in_wait", mem_req, 1'b0);
        rst_n = 1'b0;
        #1;
        chk32("rw_mem_addr", mem_addr, 32'h0);
        chk1("rw_mem_we", mem_we, 1'b0);
        chk32("rw_mem_wdata", mem_wdata, 32'h0);
        chk32("rw_mem_be", {28'd0, mem_be}, 32'h0);
        chk32("rw_if_rdata", if_rdata, 32'h0);
        chk32("rw_ls_rdata", ls_rdata, 32'h0);
        tick;
        rst_n = 1'b1;
        last_if = '0; last_ls = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        tick;
        mem_rvalid = 1'b0;
        chk_no_rvalid("rw_stray1");
        tick;
        chk_no_rvalid("rw_stray2");
        tick;
        chk_no_rvalid("rw_stray3");
        chk32("rw_ls_rdata_kept", ls_rdata, 32'h0);
        do_txn('{1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 0, 0, 32'h0BAD_CAFE, 1'b0, 32'h0, 4'hF});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
